// File: rtl/pipelined_carry_adder_if.sv
// Operand/result bus of the pipelined carry adder with valid/ready handshakes on both sides.
// master: the block feeding operands and consuming results; slave: the adder itself.
interface pipelined_carry_adder_if #(
  parameter int unsigned BW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] A;
  logic [BW-1:0] B;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] sum;
  logic          cout;
  logic          ovf;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_carry_adder.sv
// BW-bit add/subtract split into STAGES ripple-carry chunks, one chunk per stage, valid/ready flow.
// Optional macro PCA_SAT_EN: saturate sum on signed overflow (flags stay unsaturated).
module pipelined_carry_adder #(
  parameter int unsigned BW     = 32,
  parameter int unsigned STAGES = 4
) (
  input logic                  CLK,
  input logic                  RESETn,
  pipelined_carry_adder_if.slave pca_s
);

  localparam int unsigned W = BW / STAGES;

  typedef logic [BW-1:0] word_t;

  if ((STAGES < 1) || (STAGES > BW) || ((BW % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_carry_adder: BW must be a multiple of STAGES and 1 <= STAGES <= BW");
  end

  // Per-stage registers: operands (B already inverted for subtract), partial sum, carry, valid
  word_t             a_q [STAGES];
  word_t             b_q [STAGES];
  word_t             s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;

  word_t             a_d [STAGES];
  word_t             b_d [STAGES];
  word_t             s_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] v_d;
  logic              ovf_d;

  // Stage inputs: stage 0 from the bus, stage k from register k-1
  word_t             st_a [STAGES];
  word_t             st_b [STAGES];
  word_t             st_s [STAGES];
  logic [STAGES-1:0] st_c;
  logic [STAGES-1:0] st_v;

  logic              advance;
  logic [W:0]        chunk;

  // Whole pipe moves as one; a held output freezes every stage
  assign advance        = ~v_q[STAGES-1] | pca_s.out_ready;
  assign pca_s.in_ready = advance;

  always_comb begin
    st_a[0] = pca_s.A;
    st_b[0] = pca_s.sub ? ~pca_s.B : pca_s.B;
    st_s[0] = '0;
    st_c[0] = pca_s.sub | pca_s.cin;
    st_v[0] = pca_s.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_s[k] = s_q[k-1];
      st_c[k] = c_q[k-1];
      st_v[k] = v_q[k-1];
    end

    chunk = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, st_a[k][k*W +: W]} + {1'b0, st_b[k][k*W +: W]} + (W+1)'(st_c[k]);
      a_d[k]              = st_a[k];
      b_d[k]              = st_b[k];
      s_d[k]              = st_s[k];
      s_d[k][k*W +: W]    = chunk[W-1:0];
      c_d[k]              = chunk[W];
      v_d[k]              = st_v[k];
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits
    ovf_d = st_a[STAGES-1][BW-1] ^ st_b[STAGES-1][BW-1] ^ s_d[STAGES-1][BW-1] ^ c_d[STAGES-1];

`ifdef PCA_SAT_EN
    // On overflow both operand signs agree, so A's sign picks the clamp direction
    if (ovf_d) begin
      s_d[STAGES-1] = st_a[STAGES-1][BW-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign pca_s.out_valid = v_q[STAGES-1];
  assign pca_s.sum       = s_q[STAGES-1];
  assign pca_s.cout      = c_q[STAGES-1];
  assign pca_s.ovf       = ovf_q;

endmodule
